kq_hp_spi_rx: RTL and testbench



---
 rtl/kq_hp_spi_rx_pkg.sv | 23 ++
 rtl/kq_hp_spi_rx_if.sv | 28 ++
 rtl/kq_hp_spi_rx_sync_edge.sv | 39 +++
 rtl/kq_hp_spi_rx.sv | 153 +++++++++++++++
 tb/tb_kq_hp_spi_rx.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/kq_hp_spi_rx_pkg.sv
// Shared definitions for the hopping-device SPI link (transmitter and receiver).
// Holds frame layout, header codes, error causes and the receiver FSM encoding.
package kq_hp_pkg;

  localparam int         FRAME_BITS = 40;
  localparam int         HDR_BITS   = 8;
  localparam int         DATA_BITS  = 32;
  localparam logic [7:0] HDR_UP     = 8'h01;
  localparam logic [7:0] HDR_DOWN   = 8'h02;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_HDR  = 2'd2,
    ERR_TMO  = 2'd3
  } err_code_e;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;
  localparam logic [1:0] ST_WAIT_CS = 2'd3;

endpackage

// File: rtl/kq_hp_spi_rx_if.sv
// SPI pins plus decoded-frame outputs of the hopping-device receiver.
// master = transmitter/checker side, slave = the receiver itself.
interface kq_hp_spi_rx_if;

  logic        sclk_spi_hp;
  logic        cs_spi_hp;
  logic        sdo_spi_hp;
  logic [31:0] uplink_freq;
  logic        uplink_freq_vld;
  logic [31:0] downlink_freq;
  logic        downlink_freq_vld;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  modport master (
    output sclk_spi_hp, cs_spi_hp, sdo_spi_hp,
    input  uplink_freq, uplink_freq_vld, downlink_freq, downlink_freq_vld,
    input  frame_err, err_code, frame_cnt
  );

  modport slave (
    input  sclk_spi_hp, cs_spi_hp, sdo_spi_hp,
    output uplink_freq, uplink_freq_vld, downlink_freq, downlink_freq_vld,
    output frame_err, err_code, frame_cnt
  );

endinterface

// File: rtl/kq_hp_spi_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, followed by one extra
// register that provides single-cycle rise/fall pulses. STAGES must be >= 2.
module kq_hp_sync_edge #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  assign chain_d[0] = din;
  for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
    assign chain_d[gi] = chain_q[gi-1];
  end

  assign prev_d = chain_q[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign dout = chain_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/kq_hp_spi_rx.sv
// Receive-side decoder for the hopping-device SPI link: oversamples sclk/cs/sdo,
// reassembles 40-bit frames and emits uplink/downlink frequency words.
module kq_hp_spi_rx
  import kq_hp_pkg::*;
#(
  parameter int         SYNC_STAGES = 3,
  parameter int         FRAME_BITS  = kq_hp_pkg::FRAME_BITS,
  parameter int         TIMEOUT_CYC = 4096,
  parameter logic [7:0] HDR_UP      = kq_hp_pkg::HDR_UP,
  parameter logic [7:0] HDR_DOWN    = kq_hp_pkg::HDR_DOWN
) (
  input  logic           sys_clk,
  input  logic           rst,
  kq_hp_spi_rx_if.slave  bus
);

  localparam int              TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [5:0]      BITS_EXP = 6'(FRAME_BITS);

  logic sclk_rise, cs_rise, cs_fall, sdo_s;
  logic unused_sclk_lvl, unused_sclk_fall;
  logic unused_cs_lvl;
  logic unused_sdo_rise, unused_sdo_fall;

  // sclk idles low and cs idles high, so the chains start at the idle levels.
  kq_hp_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(sys_clk), .rst(rst), .din(bus.sclk_spi_hp),
    .dout(unused_sclk_lvl), .rise(sclk_rise), .fall(unused_sclk_fall)
  );

  kq_hp_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(sys_clk), .rst(rst), .din(bus.cs_spi_hp),
    .dout(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  kq_hp_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdo (
    .clk(sys_clk), .rst(rst), .din(bus.sdo_spi_hp),
    .dout(sdo_s), .rise(unused_sdo_rise), .fall(unused_sdo_fall)
  );

  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [5:0]            bc_q, bc_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [31:0]           up_q, up_d, down_q, down_d;
  logic                  up_vld_q, up_vld_d, down_vld_q, down_vld_d;
  logic                  err_pulse_q, err_pulse_d;
  err_code_e             err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            hdr;

  assign hdr = sr_q[FRAME_BITS-1 -: 8];

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bc_d        = bc_q;
    tmo_d       = tmo_q;
    up_d        = up_q;
    down_d      = down_q;
    up_vld_d    = 1'b0;
    down_vld_d  = 1'b0;
    err_pulse_d = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          sr_d    = '0;
          bc_d    = '0;
          tmo_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // cs rising wins over a coincident sclk edge, which is dropped.
        if (cs_rise) begin
          state_d = ST_CHECK;
        end else if (sclk_rise) begin
          sr_d  = {sr_q[FRAME_BITS-2:0], sdo_s};
          bc_d  = (bc_q == 6'd63) ? bc_q : bc_q + 6'd1;
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          err_pulse_d = 1'b1;
          err_d       = ERR_TMO;
          state_d     = ST_WAIT_CS;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (bc_q != BITS_EXP) begin
          err_pulse_d = 1'b1;
          err_d       = ERR_LEN;
        end else if (hdr == HDR_UP) begin
          up_d     = sr_q[31:0];
          up_vld_d = 1'b1;
          cnt_d    = cnt_q + 16'd1;
        end else if (hdr == HDR_DOWN) begin
          down_d     = sr_q[31:0];
          down_vld_d = 1'b1;
          cnt_d      = cnt_q + 16'd1;
        end else begin
          err_pulse_d = 1'b1;
          err_d       = ERR_HDR;
        end
        state_d = ST_IDLE;
      end
      default: begin
        if (cs_rise) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      bc_q        <= '0;
      tmo_q       <= '0;
      up_q        <= '0;
      down_q      <= '0;
      up_vld_q    <= 1'b0;
      down_vld_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      err_q       <= ERR_NONE;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bc_q        <= bc_d;
      tmo_q       <= tmo_d;
      up_q        <= up_d;
      down_q      <= down_d;
      up_vld_q    <= up_vld_d;
      down_vld_q  <= down_vld_d;
      err_pulse_q <= err_pulse_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.uplink_freq       = up_q;
  assign bus.uplink_freq_vld   = up_vld_q;
  assign bus.downlink_freq     = down_q;
  assign bus.downlink_freq_vld = down_vld_q;
  assign bus.frame_err         = err_pulse_q;
  assign bus.err_code          = err_q;
  assign bus.frame_cnt         = cnt_q;

endmodule

// File: tb/tb_kq_hp_spi_rx.sv
// Self-checking bench for kq_hp_spi_rx: table of frames plus hand-written
// timeout and mid-frame reset sequences, checked through an event scoreboard.
`timescale 1ns/1ps
module tb_kq_hp_spi_rx;
  import kq_hp_pkg::*;

  localparam int SYNC = 3;
  localparam int TMO  = 4096;

  typedef enum int {EV_UP, EV_DOWN, EV_ERR} ev_kind_e;

  typedef struct {
    ev_kind_e    kind;
    logic [31:0] data;
    logic [1:0]  code;
  } ev_t;

  typedef struct {
    logic [7:0]  hdr;
    logic [31:0] data;
    int          nbits;
    int          gap;
    ev_kind_e    kind;
    logic [1:0]  code;
  } vec_t;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  kq_hp_spi_rx_if bus();

  kq_hp_spi_rx #(
    .SYNC_STAGES(SYNC), .FRAME_BITS(40), .TIMEOUT_CYC(TMO),
    .HDR_UP(8'h01), .HDR_DOWN(8'h02)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;
  ev_t sb_q[$];

  logic [31:0] exp_up, exp_down;
  logic [15:0] exp_cnt;
  logic [1:0]  exp_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic take_event(input ev_kind_e kind, input logic [31:0] data, input logic [1:0] code);
    ev_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d data=%h code=%0d expected none at %0t",
               kind, data, code, $time);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || (kind != EV_ERR && e.data !== data) || (kind == EV_ERR && e.code !== code)) begin
        bad++;
        $display("FAIL event: got kind=%0d data=%h code=%0d expected kind=%0d data=%h code=%0d at %0t",
                 kind, data, code, e.kind, e.data, e.code, $time);
      end
    end
  endtask

  always @(negedge sys_clk) begin
    if (!rst) begin
      if (bus.uplink_freq_vld)   take_event(EV_UP,   bus.uplink_freq,   2'd0);
      if (bus.downlink_freq_vld) take_event(EV_DOWN, bus.downlink_freq, 2'd0);
      if (bus.frame_err)         take_event(EV_ERR,  32'd0,             bus.err_code);
    end
  end

  task automatic push(input ev_kind_e kind, input logic [31:0] data, input logic [1:0] code);
    ev_t e;
    e.kind = kind; e.data = data; e.code = code;
    sb_q.push_back(e);
    case (kind)
      EV_UP:   begin exp_up = data;   exp_cnt = exp_cnt + 16'd1; end
      EV_DOWN: begin exp_down = data; exp_cnt = exp_cnt + 16'd1; end
      default: exp_code = code;
    endcase
  endtask

  task automatic check_steady(input string tag);
    chk({tag, "_up"},    bus.uplink_freq,          exp_up);
    chk({tag, "_down"},  bus.downlink_freq,        exp_down);
    chk({tag, "_cnt"},   32'(bus.frame_cnt),       32'(exp_cnt));
    chk({tag, "_code"},  32'(bus.err_code),        32'(exp_code));
    chk({tag, "_sbq"},   32'(sb_q.size()),         32'd0);
  endtask

  // One sclk period is 8 sys_clk cycles; called and returns at a negedge.
  task automatic sclk_bit(input logic b);
    bus.sdo_spi_hp = b;
    repeat (4) @(negedge sys_clk);
    bus.sclk_spi_hp = 1'b1;
    repeat (4) @(negedge sys_clk);
    bus.sclk_spi_hp = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [31:0] data, input int nbits);
    logic [39:0] fr;
    fr = {hdr, data};
    bus.cs_spi_hp = 1'b0;
    repeat (4) @(negedge sys_clk);
    for (int i = 0; i < nbits; i++) sclk_bit((i < 40) ? fr[39-i] : 1'b0);
    repeat (4) @(negedge sys_clk);
    bus.cs_spi_hp = 1'b1;
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    vecs[0] = '{8'h01, 32'h12345678, 40, 12, EV_UP,   2'd0};
    vecs[1] = '{8'h02, 32'h89ABCDEF, 40,  4, EV_DOWN, 2'd0};
    vecs[2] = '{8'h01, 32'h00000001, 40, 12, EV_UP,   2'd0};
    vecs[3] = '{8'h01, 32'hFFFF0000, 39, 12, EV_ERR,  2'd1};
    vecs[4] = '{8'h02, 32'h0000FFFF, 41, 12, EV_ERR,  2'd1};
    vecs[5] = '{8'h03, 32'hA5A5A5A5, 40, 12, EV_ERR,  2'd2};
    vecs[6] = '{8'h01, 32'h5A5A5A5A, 70, 12, EV_ERR,  2'd1};
    vecs[7] = '{8'h00, 32'h11111111, 40, 12, EV_ERR,  2'd2};
    vecs[8] = '{8'h02, 32'h00000000, 40, 12, EV_DOWN, 2'd0};

    exp_up = '0; exp_down = '0; exp_cnt = '0; exp_code = '0;
    bus.sclk_spi_hp = 1'b0;
    bus.cs_spi_hp   = 1'b1;
    bus.sdo_spi_hp  = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_vld_up",   32'(bus.uplink_freq_vld),   32'd0);
    chk("rst_vld_down", 32'(bus.downlink_freq_vld), 32'd0);
    chk("rst_err",      32'(bus.frame_err),         32'd0);
    check_steady("rst");
    rst = 1'b0;
    repeat (10) @(negedge sys_clk);

    for (int i = 0; i < 9; i++) begin
      $display("frame %0d: hdr=%h data=%h bits=%0d gap=%0d expect kind=%0d code=%0d",
               i, vecs[i].hdr, vecs[i].data, vecs[i].nbits, vecs[i].gap, vecs[i].kind, vecs[i].code);
      push(vecs[i].kind, vecs[i].data, vecs[i].code);
      send_frame(vecs[i].hdr, vecs[i].data, vecs[i].nbits);
      if (i == 0) begin
        lat = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
          @(posedge sys_clk); #1;
          if (bus.uplink_freq_vld) lat = c;
        end
        chk("latency", 32'(lat), 32'(SYNC + 2));
        @(negedge sys_clk);
      end
      repeat (vecs[i].gap) @(negedge sys_clk);
      if (vecs[i].gap >= 10) check_steady($sformatf("vec%0d", i));
    end

    $display("timeout sequence: 10 bits then sclk idle for %0d cycles", TMO);
    push(EV_ERR, 32'd0, 2'd3);
    bus.cs_spi_hp = 1'b0;
    repeat (4) @(negedge sys_clk);
    for (int i = 0; i < 10; i++) sclk_bit(1'b1);
    repeat (TMO + 20) @(negedge sys_clk);
    chk("tmo_fired", 32'(sb_q.size()), 32'd0);
    for (int i = 0; i < 5; i++) sclk_bit(1'b1);
    repeat (4) @(negedge sys_clk);
    bus.cs_spi_hp = 1'b1;
    repeat (20) @(negedge sys_clk);
    check_steady("tmo_after");
    $display("frame post-timeout: hdr=02 data=cafef00d bits=40");
    push(EV_DOWN, 32'hCAFEF00D, 2'd0);
    send_frame(8'h02, 32'hCAFEF00D, 40);
    repeat (12) @(negedge sys_clk);
    check_steady("tmo_next");

    $display("reset sequence: reset after bit 20 of an uplink frame");
    bus.cs_spi_hp = 1'b0;
    repeat (4) @(negedge sys_clk);
    for (int i = 0; i < 20; i++) sclk_bit(i[0]);
    #2 rst = 1'b1;
    #1;
    exp_up = '0; exp_down = '0; exp_cnt = '0; exp_code = '0;
    chk("midrst_vld_up", 32'(bus.uplink_freq_vld), 32'd0);
    chk("midrst_err",    32'(bus.frame_err),       32'd0);
    check_steady("midrst");
    bus.cs_spi_hp = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    repeat (10) @(negedge sys_clk);
    check_steady("postrst");
    $display("frame post-reset: hdr=01 data=deadbeef bits=40");
    push(EV_UP, 32'hDEADBEEF, 2'd0);
    send_frame(8'h01, 32'hDEADBEEF, 40);
    repeat (12) @(negedge sys_clk);
    check_steady("rst_next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
